// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - EX/MEM/WB control pipeline with redirect and load-use hazard logic
module ctrl_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       regwr_sgn,
  input  logic       memwr_sgn,
  input  logic       alu_sgn,
  input  logic       branch,
  input  logic       jalr,
  input  logic       jump,
  input  logic [1:0] result_sgn,
  input  logic [1:0] imm_sgn,
  input  logic [1:0] alu_wire,
  input  logic [2:0] func3,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rd_d,
  input  logic       zero_e,
  input  logic       lt_e,
  input  logic       ltu_e,
  output logic       alu_sgn_e,
  output logic [1:0] alu_wire_e,
  output logic [2:0] func3_e,
  output logic [4:0] rd_e,
  output logic       pc_src_e,
  output logic       jalr_e,
  output logic       memwr_m,
  output logic       regwr_m,
  output logic [1:0] result_m,
  output logic [4:0] rd_m,
  output logic       regwr_w,
  output logic [1:0] result_w,
  output logic [4:0] rd_w,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e
);

  logic       regwr_e;
  logic [1:0] result_e;
  logic       memwr_e;
  logic       branch_e;
  logic       jump_e;
  logic       cond;
  logic       flag_sel;
  logic       lwstall;

  // imm_sgn selects the immediate format in decode only; nothing here consumes it
  logic unused_imm;
  assign unused_imm = ^imm_sgn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwr_e    <= 1'b0;
      result_e   <= 2'b00;
      memwr_e    <= 1'b0;
      alu_sgn_e  <= 1'b0;
      alu_wire_e <= 2'b00;
      branch_e   <= 1'b0;
      jalr_e     <= 1'b0;
      jump_e     <= 1'b0;
      func3_e    <= 3'b000;
      rd_e       <= 5'd0;
    end else if (flush_e) begin
      regwr_e    <= 1'b0;
      result_e   <= 2'b00;
      memwr_e    <= 1'b0;
      alu_sgn_e  <= 1'b0;
      alu_wire_e <= 2'b00;
      branch_e   <= 1'b0;
      jalr_e     <= 1'b0;
      jump_e     <= 1'b0;
      func3_e    <= 3'b000;
      rd_e       <= 5'd0;
    end else begin
      regwr_e    <= regwr_sgn;
      result_e   <= result_sgn;
      memwr_e    <= memwr_sgn;
      alu_sgn_e  <= alu_sgn;
      alu_wire_e <= alu_wire;
      branch_e   <= branch;
      jalr_e     <= jalr;
      jump_e     <= jump;
      func3_e    <= func3;
      rd_e       <= rd_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwr_m  <= 1'b0;
      result_m <= 2'b00;
      memwr_m  <= 1'b0;
      rd_m     <= 5'd0;
      regwr_w  <= 1'b0;
      result_w <= 2'b00;
      rd_w     <= 5'd0;
    end else begin
      regwr_m  <= regwr_e;
      result_m <= result_e;
      memwr_m  <= memwr_e;
      rd_m     <= rd_e;
      regwr_w  <= regwr_m;
      result_w <= result_m;
      rd_w     <= rd_m;
    end
  end

  // func3[2:1] picks the flag, func3[0] inverts it; 01x encodings are never taken
  always_comb begin
    flag_sel = func3_e[2] ? (func3_e[1] ? ltu_e : lt_e) : zero_e;
    cond     = (func3_e[2] | ~func3_e[1]) & (flag_sel ^ func3_e[0]);
  end

  assign pc_src_e = jump_e | jalr_e | (branch_e & cond);
  assign lwstall  = (result_e == 2'b01) & regwr_e & (rd_e != 5'd0) &
                    ((rd_e == rs1_d) | (rd_e == rs2_d));
  assign stall_f  = lwstall & ~pc_src_e;
  assign stall_d  = lwstall & ~pc_src_e;
  assign flush_d  = pc_src_e;
  assign flush_e  = lwstall | pc_src_e;

endmodule
